// File: rtl/muxed_dff_pipe.sv
// muxed_dff_pipe: a NUM_IN-way, WIDTH-bit select mux that feeds an elastic valid/ready register
// pipeline STAGES deep. The combinational mux output D stays visible for probing.
// Optional feature: define MUXREG_PARITY_EN to carry an even-parity bit with each stage and
// expose it on q_par.
module muxed_dff_pipe #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned NUM_IN = 4,
   parameter int unsigned SEL_W  = 2,
   parameter int unsigned STAGES = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]        sel,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    flush,
   output logic [WIDTH-1:0]        D,
   output logic [WIDTH-1:0]        Q,
   output logic                    q_valid,
   input  logic                    q_ready,
   output logic                    sel_err
`ifdef MUXREG_PARITY_EN
   ,
   output logic                    q_par
`endif
);

   logic [STAGES-1:0] v_q, v_d;
   logic [WIDTH-1:0]  data_q [STAGES];
   logic [WIDTH-1:0]  data_d [STAGES];
   logic              sel_err_q, sel_err_d;
   logic [STAGES-1:0] rdy;
   logic              sel_oob;
`ifdef MUXREG_PARITY_EN
   logic [STAGES-1:0] par_q, par_d;
`endif

   assign sel_oob = (32'(sel) >= NUM_IN);

   // Input select; out-of-range selects read as zero.
   always_comb begin
      D = '0;
      for (int unsigned k = 0; k < NUM_IN; k++) begin
         if (sel == SEL_W'(k)) begin
            D = in_data[k*WIDTH +: WIDTH];
         end
      end
   end

   // Ready chain: a stage can load if it is empty or everything downstream can move.
   always_comb begin
      logic acc;
      acc = q_ready;
      for (int i = int'(STAGES) - 1; i >= 0; i--) begin
         acc    = !v_q[i] || acc;
         rdy[i] = acc;
      end
   end

   // A beat offered during flush is dropped, so ready is masked.
   assign in_ready = rdy[0] && !flush;

   // Next-state for stage registers and the sticky select-error flag.
   always_comb begin
      v_d       = v_q;
      data_d    = data_q;
      sel_err_d = sel_err_q;
`ifdef MUXREG_PARITY_EN
      par_d     = par_q;
`endif
      if (flush) begin
         v_d = '0;
      end else begin
         if (rdy[0]) begin
            data_d[0] = D;
            v_d[0]    = in_valid;
`ifdef MUXREG_PARITY_EN
            par_d[0]  = ^D;
`endif
         end
         for (int i = 1; i < int'(STAGES); i++) begin
            if (rdy[i]) begin
               data_d[i] = data_q[i-1];
               v_d[i]    = v_q[i-1];
`ifdef MUXREG_PARITY_EN
               par_d[i]  = par_q[i-1];
`endif
            end
         end
      end
      if (in_valid && in_ready && sel_oob) begin
         sel_err_d = 1'b1;
      end
   end

   // State registers with synchronous reset taking priority over flush.
   always_ff @(posedge clk) begin
      if (rst) begin
         v_q       <= '0;
         sel_err_q <= 1'b0;
         for (int i = 0; i < int'(STAGES); i++) begin
            data_q[i] <= '0;
         end
`ifdef MUXREG_PARITY_EN
         par_q     <= '0;
`endif
      end else begin
         v_q       <= v_d;
         sel_err_q <= sel_err_d;
         data_q    <= data_d;
`ifdef MUXREG_PARITY_EN
         par_q     <= par_d;
`endif
      end
   end

   assign Q       = data_q[STAGES-1];
   assign q_valid = v_q[STAGES-1];
   assign sel_err = sel_err_q;
`ifdef MUXREG_PARITY_EN
   assign q_par   = par_q[STAGES-1];
`endif

endmodule
